branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Pipelined, parametrised branch resolution stage: evaluates conditional branches and JAL/JALR,
//  registers the result behind a valid/ready handshake and flags mispredictions against the
//  fetch-side prediction. Holds an optional saturating-counter branch history table (BHT) that
//  fetch queries and execute trains. Sits between decode/issue and the fetch redirect path.
// PARAMETERS
//  XLEN         32  datapath width; operands, PC, immediate, targets
//  BHT_ENTRIES  64  BHT depth; power of two, >= 2
//  CTR_BITS     2   BHT counter width; >= 1
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       synchronous reset, active-high
//  flush_i          in   1       kill in-flight result; input on this cycle dropped
//  valid_i          in   1       input request valid
//  ready_o          out  1       stage can accept
//  operand_a_i      in   XLEN    rs1 value
//  operand_b_i      in   XLEN    rs2 value
//  pc_i             in   XLEN    instruction PC
//  imm_i            in   XLEN    sign-extended immediate
//  branch_op_i      in   branch_op_e  comparison select
//  branch_i         in   1       conditional branch
//  jump_i           in   1       JAL or JALR
//  jalr_i           in   1       JALR (qualified by jump_i)
//  pred_taken_i     in   1       fetch predicted taken
//  pred_target_i    in   XLEN    fetch predicted target
//  valid_o          out  1       result valid
//  ready_i          in   1       consumer accepts result
//  taken_o          out  1       control transfer taken
//  target_o         out  XLEN    computed target
//  redirect_pc_o    out  XLEN    target_o if taken, else pc+4
//  mispredict_o     out  1       prediction wrong; fetch must redirect
//  misalign_o       out  1       taken and target_o[1:0] != 0
//  lookup_pc_i      in   XLEN    fetch-side BHT query PC
//  lookup_taken_o   out  1       BHT prediction for lookup_pc_i
// BEHAVIOUR
//  - Reset: valid_o=0, all data outputs 0, every BHT counter = weakly-not-taken (2^(CTR_BITS-1)-1).
//  - ready_o = !valid_o || ready_i (comb). Accept when valid_i && ready_o && !flush_i; latency 1.
//  - Result holds stable while valid_o && !ready_i; no input accepted.
//  - Condition per branch_op_e: EQ, NE, LT/GE signed, LTU/GEU unsigned; unknown op -> 0.
//  - taken = (branch_i && cond) || jump_i. Target = pc+imm, JALR: (a+imm) & ~1. XLEN wrap, no carry.
//  - Neither branch_i nor jump_i: taken=0, target=pc+imm, passes through; mispredict iff pred_taken_i.
//  - mispredict = (taken != pred_taken_i) || (taken && target != pred_target_i).
//  - misalign: target[1:0] != 0 with taken (target[0] is 0 for JALR). Reported, mispredict unchanged.
//  - flush_i: valid_o=0 next cycle regardless of ready_i; no BHT update for the dropped entry.
//  - BHT index = pc[$clog2(BHT_ENTRIES)+1:2]. Update at output handshake (valid_o && ready_i) when the
//    result is a conditional branch only. Saturating +1 if taken, -1 if not; no wrap at 0 or max.
//  - lookup_taken_o = counter MSB at lookup index (comb read). Same-cycle update to the same index:
//    lookup returns pre-update value.
//  - Reset mid-operation: pending result discarded, BHT reinitialised; no output that cycle.
// CONFIGURATION
//  BRANCH_BHT_EN defined: BHT storage, training and lookup as above.
//  BRANCH_BHT_EN undefined: no BHT flops; lookup_taken_o tied 0 (static not-taken);
//    BHT_ENTRIES/CTR_BITS unused; resolution and mispredict unaffected.
// STRUCTURE
//  rv32_pkg: branch_op_e (existing); add BHT_CTR_BITS_DEFAULT and a weakly-not-taken
//    constant function.
//  Sub-module branch_bht (storage, saturating update, comb lookup), instantiated only
//    under BRANCH_BHT_EN.
//  Top: comparator, target adders, output register, handshake.
// TESTING
//  1. BEQ a=5,b=5,pc=0x100,imm=0x20,pred_taken=0 -> next cycle valid_o=1,taken_o=1,target_o=0x120,
//     mispredict_o=1.
//  2. BLT a=0xFFFFFFFF,b=1 -> taken_o=1. BLTU same operands -> taken_o=0,
//     redirect_pc_o=pc+4.
//  3. JALR a=0x1003,imm=0,pred_taken=1,pred_target=0x1002 -> target_o=0x1002,mispredict_o=0,
//     misalign_o=1.
//  4. Hold ready_i=0 three cycles with valid_i=1 -> ready_o=0, outputs stable;
//     ready_i=1 -> next input taken.
//  5. flush_i with valid_o=1,ready_i=0 -> valid_o=0 next cycle; BHT entry unchanged.
//  6. [BRANCH_BHT_EN] pc=0x40 taken branch x3 -> lookup_taken_o(0x40) 0->1->1 saturated at 3;
//     x4 not-taken -> 0; same-cycle lookup sees old value.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 types: branch comparison ops and BHT counter defaults.
// Includes the weakly-not-taken counter value used at BHT reset.
package rv32_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_op_e;

  localparam int BHT_CTR_BITS_DEFAULT = 2;

  function automatic int unsigned bht_weak_nt(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: saturating counters, comb lookup, trained at retire.
// Instantiated only when BRANCH_BHT_EN is defined.
module branch_bht
  import rv32_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = BHT_CTR_BITS_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            upd_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o
);

  localparam int IW = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] WNT =
    CTR_BITS'(bht_weak_nt(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [IW-1:0]       upd_idx;
  logic [IW-1:0]       lk_idx;
  logic [CTR_BITS-1:0] cur;
  logic                unused_pc;

  assign upd_idx = upd_pc_i[IW+1:2];
  assign lk_idx  = lookup_pc_i[IW+1:2];
  assign cur     = ctr_q[upd_idx];

  // Flop read: a same-cycle update is only visible next cycle.
  assign lookup_taken_o = ctr_q[lk_idx][CTR_BITS-1];

  assign unused_pc = ^{upd_pc_i[XLEN-1:IW+2], upd_pc_i[1:0],
                       lookup_pc_i[XLEN-1:IW+2], lookup_pc_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else if (upd_i) begin
      if (upd_taken_i && cur != '1)
        ctr_q[upd_idx] <= cur + 1'b1;
      else if (!upd_taken_i && cur != '0)
        ctr_q[upd_idx] <= cur - 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: compare, targets, registered result, mispredict.
// Optional BHT enabled with the BRANCH_BHT_EN macro.
module branch_resolve_unit
  import rv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = BHT_CTR_BITS_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  branch_op_e      branch_op_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            mispredict_o,
  output logic            misalign_o,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o
);

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] jr_sum;
  logic [XLEN-1:0] tgt;
  logic            accept;

  logic            valid_q;
  logic            branch_q;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    cond = 1'b0;
    unique case (branch_op_i)
      BR_EQ:   cond = operand_a_i == operand_b_i;
      BR_NE:   cond = operand_a_i != operand_b_i;
      BR_LT:   cond = $signed(operand_a_i) < $signed(operand_b_i);
      BR_GE:   cond = $signed(operand_a_i) >= $signed(operand_b_i);
      BR_LTU:  cond = operand_a_i < operand_b_i;
      BR_GEU:  cond = operand_a_i >= operand_b_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = (branch_i && cond) || jump_i;
  assign jr_sum = operand_a_i + imm_i;
  assign tgt    = (jump_i && jalr_i) ? {jr_sum[XLEN-1:1], 1'b0}
                                     : pc_i + imm_i;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;
  assign valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      branch_q      <= 1'b0;
      pc_q          <= '0;
      taken_o       <= 1'b0;
      target_o      <= '0;
      redirect_pc_o <= '0;
      mispredict_o  <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      if (flush_i)     valid_q <= 1'b0;
      else if (accept) valid_q <= 1'b1;
      else if (ready_i) valid_q <= 1'b0;
      if (accept) begin
        branch_q      <= branch_i && !jump_i;
        pc_q          <= pc_i;
        taken_o       <= taken;
        target_o      <= tgt;
        redirect_pc_o <= taken ? tgt : pc_i + XLEN'(4);
        mispredict_o  <= (taken != pred_taken_i) ||
                         (taken && tgt != pred_target_i);
        misalign_o    <= taken && (tgt[1:0] != 2'b00);
      end
    end
  end

`ifdef BRANCH_BHT_EN
  logic bht_upd;

  // A flushed result never retires, so it must not train.
  assign bht_upd = valid_q && ready_i && !flush_i && branch_q;

  branch_bht #(
    .XLEN     (XLEN),
    .ENTRIES  (BHT_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_bht (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .upd_i          (bht_upd),
    .upd_pc_i       (pc_q),
    .upd_taken_i    (taken_o),
    .lookup_pc_i    (lookup_pc_i),
    .lookup_taken_o (lookup_taken_o)
  );
`else
  logic unused_bht;

  assign lookup_taken_o = 1'b0;
  assign unused_bht = ^{lookup_pc_i, pc_q, branch_q,
                        32'(BHT_ENTRIES), 32'(CTR_BITS)};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases then random
// traffic against a behavioural model (BHT checked if BRANCH_BHT_EN).
module tb_branch_resolve_unit;
  import rv32_pkg::*;

  localparam int ENT = 64;
  localparam int CB  = 2;
`ifdef BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_o;
  logic [31:0] operand_a_i, operand_b_i, pc_i, imm_i;
  branch_op_e  branch_op_i;
  logic        branch_i, jump_i, jalr_i, pred_taken_i;
  logic [31:0] pred_target_i;
  logic        valid_o, ready_i, taken_o;
  logic [31:0] target_o, redirect_pc_o;
  logic        mispredict_o, misalign_o;
  logic [31:0] lookup_pc_i;
  logic        lookup_taken_o;

  branch_resolve_unit #(
    .XLEN(32), .BHT_ENTRIES(ENT), .CTR_BITS(CB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .pc_i(pc_i), .imm_i(imm_i), .branch_op_i(branch_op_i),
    .branch_i(branch_i), .jump_i(jump_i), .jalr_i(jalr_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .valid_o(valid_o), .ready_i(ready_i), .taken_o(taken_o),
    .target_o(target_o), .redirect_pc_o(redirect_pc_o),
    .mispredict_o(mispredict_o), .misalign_o(misalign_o),
    .lookup_pc_i(lookup_pc_i), .lookup_taken_o(lookup_taken_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        tk;
    bit [31:0] tgt;
    bit [31:0] rpc;
    bit        mis;
    bit        mal;
  } res_t;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mv;
  res_t mr;
  bit   mbr;
  bit [31:0] mpc;
  int   bht [ENT];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_model(
    input branch_op_e op, input bit [31:0] a, input bit [31:0] b,
    input bit [31:0] pc, input bit [31:0] imm, input bit br,
    input bit jmp, input bit jr, input bit pt, input bit [31:0] ptg);
    res_t r;
    bit c;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      BR_EQ:   c = a == b;
      BR_NE:   c = a != b;
      BR_LT:   c = sa < sb;
      BR_GE:   c = sa >= sb;
      BR_LTU:  c = a < b;
      BR_GEU:  c = a >= b;
      default: c = 0;
    endcase
    r.tk  = (br && c) || jmp;
    r.tgt = (jmp && jr) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
    r.rpc = r.tk ? r.tgt : pc + 32'd4;
    r.mis = (r.tk != pt) || (r.tk && r.tgt != ptg);
    r.mal = r.tk && (r.tgt % 4 != 0);
    return r;
  endfunction

  function automatic int bidx(input bit [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic bit exp_lookup(input bit [31:0] pc);
    if (!BHT_ON) return 1'b0;
    return bht[bidx(pc)] >= (1 << (CB - 1));
  endfunction

  task automatic model_reset();
    mv  = 0;
    mr  = '{tk: 0, tgt: 0, rpc: 0, mis: 0, mal: 0};
    mbr = 0;
    mpc = 0;
    for (int i = 0; i < ENT; i++) bht[i] = (1 << (CB - 1)) - 1;
  endtask

  task automatic chk_out();
    chk("valid_o", valid_o, mv);
    chk("taken_o", taken_o, mr.tk);
    chk("target_o", target_o, mr.tgt);
    chk("redirect_pc_o", redirect_pc_o, mr.rpc);
    chk("mispredict_o", mispredict_o, mr.mis);
    chk("misalign_o", misalign_o, mr.mal);
  endtask

  task automatic step();
    res_t nr;
    #1;
    chk("ready_o", ready_o, !mv || ready_i);
    chk("lookup_taken_o", lookup_taken_o, exp_lookup(lookup_pc_i));
    nr = ref_model(branch_op_i, operand_a_i, operand_b_i, pc_i, imm_i,
                   branch_i, jump_i, jalr_i, pred_taken_i, pred_target_i);
    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else begin
      if (mv && ready_i && !flush_i && mbr) begin
        if (mr.tk && bht[bidx(mpc)] < (1 << CB) - 1)
          bht[bidx(mpc)]++;
        else if (!mr.tk && bht[bidx(mpc)] > 0)
          bht[bidx(mpc)]--;
      end
      if (flush_i) mv = 0;
      else if (valid_i && (!mv || ready_i)) begin
        mv  = 1;
        mr  = nr;
        mbr = branch_i && !jump_i;
        mpc = pc_i;
      end else if (ready_i) mv = 0;
    end
    #1;
    chk_out();
  endtask

  task automatic set_br(input branch_op_e op, input bit [31:0] a,
                        input bit [31:0] b, input bit [31:0] pc,
                        input bit [31:0] imm, input bit br, input bit jmp,
                        input bit jr, input bit pt, input bit [31:0] ptg);
    valid_i = 1; branch_op_i = op;
    operand_a_i = a; operand_b_i = b;
    pc_i = pc; imm_i = imm;
    branch_i = br; jump_i = jmp; jalr_i = jr;
    pred_taken_i = pt; pred_target_i = ptg;
  endtask

  task automatic rand_in();
    int kind;
    bit [31:0] t;
    rst_i   = $urandom_range(0, 99) == 0;
    flush_i = $urandom_range(0, 15) == 0;
    valid_i = $urandom_range(0, 3) != 0;
    ready_i = $urandom_range(0, 3) != 0;
    kind    = $urandom_range(0, 3);
    branch_i = kind < 2;
    jump_i   = kind == 2;
    jalr_i   = $urandom_range(0, 1) == 1;
    branch_op_i = branch_op_e'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      operand_a_i = $urandom_range(0, 3);
      operand_b_i = $urandom_range(0, 3);
    end else begin
      operand_a_i = $urandom;
      operand_b_i = $urandom;
    end
    if ($urandom_range(0, 3) == 0) operand_b_i = operand_a_i;
    pc_i  = $urandom_range(0, 31) * 4;
    imm_i = $urandom_range(0, 255) - 128;
    pred_taken_i = $urandom_range(0, 1) == 1;
    t = (jump_i && jalr_i) ? ((operand_a_i + imm_i) & 32'hFFFF_FFFE)
                           : pc_i + imm_i;
    pred_target_i = ($urandom_range(0, 1) == 1) ? t : $urandom;
    lookup_pc_i = ($urandom_range(0, 1) == 1) ? mpc
                                              : $urandom_range(0, 63) * 4;
  endtask

  bit tk_pre  [3] = '{0, 1, 1};
  bit tk_post [3] = '{1, 1, 1};
  bit nt_post [4] = '{1, 0, 0, 0};

  initial begin
    rst_i = 1; flush_i = 0; ready_i = 1; lookup_pc_i = 32'h40;
    set_br(BR_EQ, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    valid_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_i = 0;
    chk("rst_valid", valid_o, 0);
    chk("rst_target", target_o, 0);
    chk("rst_redirect", redirect_pc_o, 0);
    chk("rst_misp", mispredict_o, 0);
    chk("rst_lookup", lookup_taken_o, 0);

    set_br(BR_EQ, 5, 5, 32'h100, 32'h20, 1, 0, 0, 0, 0);
    step();
    chk("t1_valid", valid_o, 1);
    chk("t1_taken", taken_o, 1);
    chk("t1_target", target_o, 32'h120);
    chk("t1_misp", mispredict_o, 1);

    set_br(BR_LT, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 1, 0, 0, 1, 32'h210);
    step();
    chk("t2_blt", taken_o, 1);
    set_br(BR_LTU, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 1, 0, 0, 0, 0);
    step();
    chk("t2_bltu", taken_o, 0);
    chk("t2_redir", redirect_pc_o, 32'h204);

    set_br(BR_EQ, 32'h1003, 0, 32'h300, 0, 0, 1, 1, 1, 32'h1002);
    step();
    chk("t3_target", target_o, 32'h1002);
    chk("t3_misp", mispredict_o, 0);
    chk("t3_mal", misalign_o, 1);

    ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      set_br(BR_NE, k, 0, 32'h500 + 4 * k, 4, 1, 0, 0, 0, 0);
      step();
      chk("t4_ready", ready_o, 0);
      chk("t4_hold", target_o, 32'h1002);
    end
    ready_i = 1;
    set_br(BR_EQ, 0, 0, 32'h400, 8, 1, 0, 0, 1, 32'h408);
    step();
    chk("t4_next", target_o, 32'h408);

    set_br(BR_EQ, 1, 1, 32'h40, 4, 1, 0, 0, 0, 0);
    step();
    ready_i = 0; flush_i = 1;
    step();
    chk("t5_flush", valid_o, 0);
    flush_i = 0; ready_i = 1; valid_i = 0;
    step();
    chk("t5_bht", lookup_taken_o, 0);

    for (int k = 0; k < 3; k++) begin
      set_br(BR_EQ, 1, 1, 32'h40, 4, 1, 0, 0, 1, 32'h44);
      step();
      valid_i = 0;
      chk("t6_same", lookup_taken_o, BHT_ON ? tk_pre[k] : 1'b0);
      step();
      chk("t6_tk", lookup_taken_o, BHT_ON ? tk_post[k] : 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      set_br(BR_NE, 1, 1, 32'h40, 4, 1, 0, 0, 0, 0);
      step();
      valid_i = 0;
      step();
      chk("t6_nt", lookup_taken_o, BHT_ON ? nt_post[k] : 1'b0);
    end

    set_br(BR_EQ, 2, 2, 32'h80, 4, 1, 0, 0, 0, 0);
    step();
    rst_i = 1;
    step();
    chk("rst_mid", valid_o, 0);
    rst_i = 0;

    for (int n = 0; n < 3000; n++) begin
      rand_in();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
